// File: rtl/tracking_arbiter_pkg.sv
// Shared definitions for the tracking-loop arbiter.
//   - arb_state_e : arbiter FSM encoding (idle / issue / wait-for-engine)
//   - chan_idx_w  : channel-index width, never narrower than one bit
//   - payload_t   : packed channel-history layout (i2q2 E/P/L, iq/i/q prompt, w_df, w_df_dot)
//   - result_t    : packed tracking-result layout
package tracking_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Field layout of the default 128-bit channel history, MSB first.
    typedef struct packed {
        logic [15:0] i2q2_early;
        logic [15:0] i2q2_prompt;
        logic [15:0] i2q2_late;
        logic [15:0] iq_prompt;
        logic [15:0] i_prompt;
        logic [15:0] q_prompt;
        logic [15:0] w_df;
        logic [15:0] w_df_dot;
    } payload_t;

    // Field layout of the default 96-bit tracking result, MSB first.
    typedef struct packed {
        logic [15:0] iq_prompt_k;
        logic [23:0] doppler_inc_kp1;
        logic [15:0] w_df_kp1;
        logic [15:0] w_df_dot_kp1;
        logic [23:0] ca_dphi_kp1;
    } result_t;

endpackage

// File: rtl/tracking_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   pending_i    : request vector
//   last_grant_i : channel granted most recently
//   grant_o      : first requesting channel scanning upward from last_grant_i+1 (wrapping)
//   any_req_o    : at least one request present
module tracking_arbiter_rr_arbiter
    import tracking_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4
) (
    input  logic [NUM_CHANNELS-1:0]             pending_i,
    input  logic [chan_idx_w(NUM_CHANNELS)-1:0] last_grant_i,
    output logic [chan_idx_w(NUM_CHANNELS)-1:0] grant_o,
    output logic                                any_req_o
);

    localparam int unsigned IdxW = chan_idx_w(NUM_CHANNELS);

    int unsigned            idx;
    logic [IdxW-1:0]        cand;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = NUM_CHANNELS; k >= 1; k--) begin
            idx  = (32'(last_grant_i) + k) % NUM_CHANNELS;
            cand = IdxW'(idx);
            if (pending_i[cand]) begin
                grant_o   = cand;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tracking_arbiter.sv
// Shares one tracking-loop engine among NUM_CHANNELS correlator channels.
//   clk, reset   : clock, synchronous active-high reset
//   ch_enable    : per-channel enable; clearing it drops a pending request
//   ch_valid     : per-channel request strobe
//   ch_payload   : flattened channel histories, channel i at [i*PAYLOAD_W +: PAYLOAD_W]
//   eng_start    : one-cycle engine start strobe
//   eng_payload  : history of the channel in service, held until the next start
//   eng_chan     : index of the channel in service
//   eng_ready    : engine completion strobe, eng_result valid with it
//   res_valid    : one-hot registered result strobe to the owning channel
//   res_data     : registered result data
//   overrun      : sticky; unserved request overwritten by a newer one
//   timeout_err  : sticky; engine did not finish within TIMEOUT cycles
//   busy         : a job is being issued or awaited
module tracking_arbiter
    import tracking_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned PAYLOAD_W    = 128,
    parameter int unsigned RESULT_W     = 96,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             ch_enable,
    input  logic [NUM_CHANNELS-1:0]             ch_valid,
    input  logic [NUM_CHANNELS*PAYLOAD_W-1:0]   ch_payload,
    output logic                                eng_start,
    output logic [PAYLOAD_W-1:0]                eng_payload,
    output logic [chan_idx_w(NUM_CHANNELS)-1:0] eng_chan,
    input  logic                                eng_ready,
    input  logic [RESULT_W-1:0]                 eng_result,
    output logic [NUM_CHANNELS-1:0]             res_valid,
    output logic [RESULT_W-1:0]                 res_data,
    output logic [NUM_CHANNELS-1:0]             overrun,
    output logic                                timeout_err,
    output logic                                busy
);

    localparam int unsigned CHAN_IDX_W = chan_idx_w(NUM_CHANNELS);
    localparam int unsigned TIMER_W    = $clog2(TIMEOUT + 1);

    arb_state_e              state_q, state_d;
    logic [CHAN_IDX_W-1:0]   sel_q, sel_d;
    logic [CHAN_IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CHAN_IDX_W-1:0]   grant;
    logic                    any_req;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;
    logic [NUM_CHANNELS-1:0] res_valid_q, res_valid_d;
    logic [NUM_CHANNELS-1:0] capture;
    logic [NUM_CHANNELS-1:0] issue_oh;
    logic [PAYLOAD_W-1:0]    holding_q [NUM_CHANNELS];
    logic [PAYLOAD_W-1:0]    holding_d [NUM_CHANNELS];
    logic [PAYLOAD_W-1:0]    eng_payload_q, eng_payload_d;
    logic [RESULT_W-1:0]     res_data_q, res_data_d;
    logic                    timeout_err_q, timeout_err_d;

    assign capture = ch_valid & ch_enable;

    always_comb begin
        issue_oh = '0;
        if (state_q == StIssue) begin
            issue_oh[sel_q] = 1'b1;
        end
    end

    // Disabled channels are masked so a request dropped this cycle cannot win.
    tracking_arbiter_rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_rr (
        .pending_i    (pending_q & ch_enable),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .any_req_o    (any_req)
    );

    // Per-channel holding registers and pending/overrun flags.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        holding_d = holding_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!ch_enable[i]) begin
                pending_d[i] = 1'b0;
            end else if (capture[i]) begin
                holding_d[i] = ch_payload[i*PAYLOAD_W +: PAYLOAD_W];
                pending_d[i] = 1'b1;
                // A request landing in its own issue cycle is a fresh one, not an overwrite.
                if (pending_q[i] && !issue_oh[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end else if (issue_oh[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Timer holds the ordinal of the current engine cycle: 1 in the start cycle.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_grant_d  = last_grant_q;
        timer_d       = timer_q;
        eng_payload_d = eng_payload_q;
        res_valid_d   = '0;
        res_data_d    = res_data_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    sel_d        = grant;
                    last_grant_d = grant;
                    timer_d      = TIMER_W'(1);
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                eng_payload_d = holding_q[sel_q];
                timer_d       = timer_q + TIMER_W'(1);
                state_d       = StWait;
            end
            StWait: begin
                if (eng_ready) begin
                    res_valid_d[sel_q] = 1'b1;
                    res_data_d         = eng_result;
                    state_d            = StIdle;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sel_q         <= '0;
            last_grant_q  <= CHAN_IDX_W'(NUM_CHANNELS - 1);
            timer_q       <= '0;
            pending_q     <= '0;
            overrun_q     <= '0;
            holding_q     <= '{default: '0};
            eng_payload_q <= '0;
            res_valid_q   <= '0;
            res_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            holding_q     <= holding_d;
            eng_payload_q <= eng_payload_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign eng_start   = (state_q == StIssue);
    assign eng_payload = (state_q == StIssue) ? holding_q[sel_q] : eng_payload_q;
    assign eng_chan    = sel_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_tracking_arbiter.sv
module tb_tracking_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 128;
    localparam int unsigned RW  = 96;
    localparam int unsigned TMO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*PW-1:0] ch_payload;
    logic              eng_start;
    logic [PW-1:0]     eng_payload;
    logic [1:0]        eng_chan;
    logic              eng_ready;
    logic [RW-1:0]     eng_result;
    logic [NCH-1:0]    res_valid;
    logic [RW-1:0]     res_data;
    logic [NCH-1:0]    overrun;
    logic              timeout_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected grants and expected results, in order.
    int            exp_chan_q[$];
    logic [PW-1:0] exp_pay_q[$];
    int            exp_rchan_q[$];
    logic [RW-1:0] exp_rdata_q[$];

    always #5 clk = ~clk;

    tracking_arbiter #(
        .NUM_CHANNELS (NCH),
        .PAYLOAD_W    (PW),
        .RESULT_W     (RW),
        .TIMEOUT      (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_enable   (ch_enable),
        .ch_valid    (ch_valid),
        .ch_payload  (ch_payload),
        .eng_start   (eng_start),
        .eng_payload (eng_payload),
        .eng_chan    (eng_chan),
        .eng_ready   (eng_ready),
        .eng_result  (eng_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ch_enable  = '1;
        ch_valid   = '0;
        ch_payload = '0;
        eng_ready  = 1'b0;
        eng_result = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_chan_q.delete();
        exp_pay_q.delete();
        exp_rchan_q.delete();
        exp_rdata_q.delete();
    endtask

    task automatic set_req(input int ch, input logic [PW-1:0] pay);
        ch_valid[ch]            = 1'b1;
        ch_payload[ch*PW +: PW] = pay;
    endtask

    // Waits (bounded) for eng_start, lets the engine take lat cycles, pulses eng_ready,
    // and returns what was observed at start and one cycle after eng_ready.
    task automatic run_job(input int lat, input logic [RW-1:0] result, output bit started,
                           output int waited, output int chan, output logic [PW-1:0] pay,
                           output logic [NCH-1:0] rv, output logic [RW-1:0] rd);
        started = 1'b0;
        waited  = 0;
        chan    = -1;
        pay     = '0;
        rv      = '0;
        rd      = '0;
        while (!started && waited < 40) begin
            if (eng_start === 1'b1) started = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        if (!started) return;
        chan = int'(eng_chan);
        pay  = eng_payload;
        for (int k = 0; k < lat; k++) tick();
        eng_ready  = 1'b1;
        eng_result = result;
        tick();
        eng_ready = 1'b0;
        rv = res_valid;
        rd = res_data;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ch_enable  = '1;
        ch_valid   = '0;
        ch_payload = '0;
        eng_ready  = 1'b0;
        eng_result = '0;
        tick();
        tick();
        n_tests++;
        if ({eng_start, eng_payload, eng_chan, res_valid, res_data, overrun, timeout_err, busy}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b chan=%0d rv=%b ovr=%b tmo=%b busy=%b want all 0",
                     eng_start, eng_chan, res_valid, overrun, timeout_err, busy);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b start=%b want 0 0", busy, eng_start);
        end
    endtask

    task automatic test_single();
        bit started; int w, ch, ech; logic [PW-1:0] pay, epay;
        logic [NCH-1:0] rv; logic [RW-1:0] rd, erd;
        do_reset();
        set_req(2, 128'hA5A5);
        exp_chan_q.push_back(2);
        exp_pay_q.push_back(128'hA5A5);
        exp_rchan_q.push_back(2);
        exp_rdata_q.push_back(96'h1234);
        tick();
        ch_valid = '0;
        run_job(10, 96'h1234, started, w, ch, pay, rv, rd);
        n_tests++;
        if (!started || w != 1) begin
            n_fail++;
            $display("FAIL single_latency: started=%0d extra_wait=%0d want 1 1", started, w);
        end
        ech = exp_chan_q.pop_front();
        epay = exp_pay_q.pop_front();
        n_tests++;
        if (ch != ech || pay !== epay) begin
            n_fail++;
            $display("FAIL single_grant: chan=%0d pay=%h want %0d %h", ch, pay, ech, epay);
        end
        ech = exp_rchan_q.pop_front();
        erd = exp_rdata_q.pop_front();
        n_tests++;
        if (rv !== NCH'(1 << ech) || rd !== erd || overrun !== '0) begin
            n_fail++;
            $display("FAIL single_result: rv=%b data=%h ovr=%b want %b %h 0000",
                     rv, rd, overrun, NCH'(1 << ech), erd);
        end
        tick();
        n_tests++;
        if (res_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe: rv=%b busy=%b want 0000 0", res_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        bit started; int w, ch, ech; logic [PW-1:0] pay, epay;
        logic [NCH-1:0] rv; logic [RW-1:0] rd, erd;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            set_req(i, 128'hC000 + PW'(i));
            exp_chan_q.push_back(i);
            exp_pay_q.push_back(128'hC000 + PW'(i));
            exp_rchan_q.push_back(i);
            exp_rdata_q.push_back(96'hD000 + RW'(i));
        end
        tick();
        ch_valid = '0;
        for (int i = 0; i < NCH; i++) begin
            run_job(1 + i, 96'hD000 + RW'(i), started, w, ch, pay, rv, rd);
            ech = exp_chan_q.pop_front();
            epay = exp_pay_q.pop_front();
            n_tests++;
            if (!started || ch != ech || pay !== epay) begin
                n_fail++;
                $display("FAIL simul_grant%0d: chan=%0d pay=%h want %0d %h", i, ch, pay, ech, epay);
            end
            ech = exp_rchan_q.pop_front();
            erd = exp_rdata_q.pop_front();
            n_tests++;
            if (rv !== NCH'(1 << ech) || rd !== erd) begin
                n_fail++;
                $display("FAIL simul_result%0d: rv=%b data=%h want %b %h", i, rv, rd,
                         NCH'(1 << ech), erd);
            end
        end
    endtask

    task automatic test_fairness();
        bit started; int w, ch, ech; logic [PW-1:0] pay;
        logic [NCH-1:0] rv; logic [RW-1:0] rd;
        do_reset();
        set_req(0, 128'hF0);
        set_req(3, 128'hF3);
        for (int j = 0; j < 4; j++) exp_chan_q.push_back((j % 2 == 0) ? 0 : 3);
        for (int j = 0; j < 4; j++) begin
            run_job(3, 96'hE0 + RW'(j), started, w, ch, pay, rv, rd);
            ech = exp_chan_q.pop_front();
            n_tests++;
            if (!started || ch != ech) begin
                n_fail++;
                $display("FAIL fair_grant%0d: chan=%0d want %0d", j, ch, ech);
            end
        end
        ch_valid = '0;
    endtask

    task automatic test_overrun();
        bit started; int w, ch; logic [PW-1:0] pay;
        logic [NCH-1:0] rv; logic [RW-1:0] rd;
        do_reset();
        set_req(0, 128'h0A0A);
        tick();
        ch_valid = '0;
        tick();
        tick();
        set_req(1, 128'h1111);
        tick();
        set_req(1, 128'h2222);
        tick();
        ch_valid = '0;
        n_tests++;
        if (overrun !== 4'b0010) begin
            n_fail++;
            $display("FAIL overrun_flag: ovr=%b want 0010", overrun);
        end
        eng_ready = 1'b1;
        eng_result = 96'h0A;
        tick();
        eng_ready = 1'b0;
        run_job(2, 96'h22, started, w, ch, pay, rv, rd);
        n_tests++;
        if (!started || ch != 1 || pay !== 128'h2222 || rv !== 4'b0010) begin
            n_fail++;
            $display("FAIL overrun_payload: chan=%0d pay=%h rv=%b want 1 2222 0010", ch, pay, rv);
        end
        // Re-request in the channel's own issue cycle.
        do_reset();
        set_req(1, 128'h4444);
        tick();
        ch_valid = '0;
        tick();
        n_tests++;
        if (eng_start !== 1'b1 || eng_chan !== 2'd1) begin
            n_fail++;
            $display("FAIL issue_cycle: start=%b chan=%0d want 1 1", eng_start, eng_chan);
        end
        set_req(1, 128'h3333);
        tick();
        ch_valid = '0;
        n_tests++;
        if (overrun !== '0) begin
            n_fail++;
            $display("FAIL issue_rereq_ovr: ovr=%b want 0000", overrun);
        end
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        run_job(1, 96'h33, started, w, ch, pay, rv, rd);
        n_tests++;
        if (!started || ch != 1 || pay !== 128'h3333) begin
            n_fail++;
            $display("FAIL issue_rereq_pay: chan=%0d pay=%h want 1 3333", ch, pay);
        end
    endtask

    task automatic test_timeout();
        logic [NCH-1:0] seen;
        // Engine answers in the last allowed cycle.
        do_reset();
        set_req(0, 128'hAB);
        tick();
        ch_valid = '0;
        tick();
        for (int k = 0; k < TMO - 1; k++) tick();
        eng_ready = 1'b1;
        eng_result = 96'hBEEF;
        tick();
        eng_ready = 1'b0;
        n_tests++;
        if (res_valid !== 4'b0001 || res_data !== 96'hBEEF || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_edge_ready: rv=%b data=%h tmo=%b want 0001 beef 0",
                     res_valid, res_data, timeout_err);
        end
        // Engine never answers.
        do_reset();
        set_req(0, 128'hB0);
        set_req(1, 128'hB1);
        tick();
        ch_valid = '0;
        tick();
        seen = '0;
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            seen |= res_valid;
        end
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: tmo=%b busy=%b want 0 1", timeout_err, busy);
        end
        tick();
        seen |= res_valid;
        n_tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: tmo=%b busy=%b want 1 0", timeout_err, busy);
        end
        tick();
        seen |= res_valid;
        n_tests++;
        if (eng_start !== 1'b1 || eng_chan !== 2'd1 || seen !== '0) begin
            n_fail++;
            $display("FAIL tmo_next: start=%b chan=%0d rv_seen=%b want 1 1 0000",
                     eng_start, eng_chan, seen);
        end
    endtask

    task automatic test_reset_disable();
        bit started; int w, ch; logic [PW-1:0] pay;
        logic [NCH-1:0] rv; logic [RW-1:0] rd;
        int starts;
        do_reset();
        set_req(3, 128'h77);
        tick();
        ch_valid = '0;
        run_job(2, 96'h99, started, w, ch, pay, rv, rd);
        set_req(1, 128'h55);
        tick();
        ch_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eng_ready = 1'b1;
        eng_result = 96'hEE;
        tick();
        eng_ready = 1'b0;
        n_tests++;
        if ({eng_start, eng_payload, eng_chan, res_valid, res_data, overrun, timeout_err, busy}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_midjob: rv=%b data=%h chan=%0d pay=%h busy=%b want all 0",
                     res_valid, res_data, eng_chan, eng_payload, busy);
        end
        tick();
        n_tests++;
        if (res_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_late_ready: rv=%b busy=%b want 0000 0", res_valid, busy);
        end
        // Disable a pending channel while another is in service.
        do_reset();
        set_req(0, 128'h1);
        tick();
        ch_valid = '0;
        tick();
        tick();
        set_req(2, 128'h2);
        tick();
        ch_valid = '0;
        ch_enable = 4'b1011;
        tick();
        ch_enable = '1;
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (eng_start === 1'b1) starts++;
        end
        n_tests++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL disable_drop: starts=%0d want 0", starts);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overrun();
        test_timeout();
        test_reset_disable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule

// File: doc/tracking_arbiter.md
Name: tracking_arbiter

Overview:
- Shares one tracking-loop engine among N correlator channels, generalising the single-channel wiring of channel history into tracking results.
- Each channel's accumulation-complete strobe and history payload are latched into a per-channel holding register. Requests are granted round-robin to the engine.
- Each engine result is routed back to the originating channel as a one-cycle strobe.
- Adds overrun detection, an engine watchdog timeout and per-channel enables.

Parameters:
NUM_CHANNELS, 4, number of client channels (>=2)
PAYLOAD_W, 128, packed channel-history width (i2q2 early/prompt/late, iq/i/q prompt, w_df, w_df_dot)
RESULT_W, 96, packed tracking-result width (iq_prompt_k, doppler_inc_kp1, w_df_kp1, w_df_dot_kp1, ca_dphi_kp1)
TIMEOUT, 1024, maximum engine cycles from start to ready before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ch_enable  in  NUM_CHANNELS  per-channel enable; a disabled channel's requests are ignored and its pending request is dropped
ch_valid  in  NUM_CHANNELS  per-channel request strobe (i2q2_valid)
ch_payload  in  NUM_CHANNELS*PAYLOAD_W  flattened; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
eng_start  out  1  one-cycle engine start strobe
eng_payload  out  PAYLOAD_W  payload presented to engine; stable from eng_start until eng_ready or timeout
eng_chan  out  CHAN_IDX_W  index of the channel in service
eng_ready  in  1  engine completion strobe (tracking_ready)
eng_result  in  RESULT_W  engine result, valid with eng_ready
res_valid  out  NUM_CHANNELS  one-hot result strobe to the owning channel
res_data  out  RESULT_W  result data, valid with res_valid
overrun  out  NUM_CHANNELS  sticky; request arrived while the channel's previous request was still pending
timeout_err  out  1  sticky; engine exceeded TIMEOUT
busy  out  1  high in ISSUE or WAIT

Behaviour:
- All outputs are reset to 0. Reset also clears the pending bits, holding registers, timer and state (to IDLE). The last-grant pointer resets to NUM_CHANNELS-1, so channel 0 wins the first arbitration.
- Reset asserted mid-operation abandons any in-flight engine job. An eng_ready arriving afterwards is ignored.
- Capture, per channel i, when ch_valid[i]&ch_enable[i]:
  - holding[i] <= payload and pending[i] <= 1 at the next edge.
  - If pending[i] was already 1 and the request has not yet been issued, the new payload overwrites the old one and overrun[i] sets.
- A channel currently in service is not pending. A new request from it is a normal capture.
- ch_enable[i]=0 clears pending[i] at the next edge. It does not affect an already-issued job.
- State IDLE:
  - If any pending bit is set, select the first pending channel scanning upward from last_grant+1, wrapping modulo NUM_CHANNELS.
  - Register sel and last_grant<=sel, then go to ISSUE.
  - A request captured in cycle t is eligible in IDLE at t+1.
- State ISSUE (1 cycle):
  - eng_start=1, with eng_chan=sel and eng_payload=holding[sel].
  - Clear pending[sel]. If ch_valid[sel] is asserted in this same cycle, pending[sel] stays set with the new payload and overrun is not set.
  - Clear the timer, then go to WAIT.
- State WAIT:
  - The timer increments each cycle.
  - On eng_ready: res_valid[sel]=1 and res_data=eng_result on the next cycle (registered, 1-cycle latency), then return to IDLE.
  - If the timer reaches TIMEOUT before eng_ready: set timeout_err, produce no result, return to IDLE.
  - eng_ready and timer==TIMEOUT in the same cycle: eng_ready wins, the result is delivered and there is no error.
- eng_ready outside WAIT is ignored.
- eng_payload/eng_chan hold their values from ISSUE until the next ISSUE.
- Throughput: minimum 3 cycles per job plus engine latency. Round-robin guarantees each continuously requesting channel is served at least once per NUM_CHANNELS jobs.
- Width rules:
  - CHAN_IDX_W = max(1, clog2(NUM_CHANNELS)).
  - Timer width = clog2(TIMEOUT+1).
  - No arithmetic on payload or result; pure data steering.

Decomposition:
- Shared package/header (alongside the tracking-loop header): CHAN_IDX_W, the payload and result field offsets (I2Q2, IQ, ACC_TRACK, W_DF, W_DF_DOT, DOPPLER_INC, CA_PHASE_INC ranges), and the state encoding macros.
- One natural sub-module: rr_arbiter. Inputs are the pending vector and last_grant; outputs are the grant index and any_req. It is combinational, parametrised by NUM_CHANNELS.

Test Plan:
- Single request: ch_valid=4'b0100, payload 0xA5A5, engine ready 10 cycles after eng_start with result 0x1234. Required response: eng_start 2 cycles after ch_valid, eng_chan=2, eng_payload=0xA5A5; res_valid=4'b0100 and res_data=0x1234 the cycle after eng_ready; overrun=0.
- Simultaneous requests: ch_valid=4'b1111 in one cycle. Required response: grants in order 0,1,2,3; four res_valid strobes in that order.
- Fairness: channels 0 and 3 request continuously. Required response: grants alternate 0,3,0,3; channel 3 never waits more than one job.
- Overrun: channel 1 requests twice while channel 0 is in service, payloads 0x1111 then 0x2222. Required response: overrun[1]=1 and eng_payload=0x2222 for channel 1; re-request in channel 1's own ISSUE cycle sets no overrun.
- Timeout: TIMEOUT=64, engine never responds. Required response: timeout_err=1 and busy=0 exactly 64 cycles after eng_start, no res_valid, next pending channel issued; eng_ready at timer==64 delivers the result instead.
- Reset/disable: assert reset during WAIT, then eng_ready. Required response: no res_valid and all outputs 0. Separately, clear ch_enable[2] while pending[2]=1: channel 2 is never issued.
